abc_stim_checker: RTL and testbench

ABC_STIM_CHECKER -- requirements
Module: abc_stim_checker

---
 rtl/abc_stim_pkg.sv | 20 ++
 rtl/abc_step_table.sv | 33 +++
 rtl/abc_stim_checker.sv | 188 ++++++++++++++++++
 tb/tb_abc_stim_checker.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/abc_stim_pkg.sv
// abc_stim_checker shared types: step layout, FSM states, defaults.
// Optional build macro: FIRST_FAIL_EN (first-mismatch capture ports).
package abc_stim_pkg;

    localparam int DEPTH_DEF  = 8;
    localparam int HOLD_W_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [2:0]            abc;
        logic                  expz;
        logic [HOLD_W_DEF-1:0] hold;
    } step_t;

endpackage

// File: rtl/abc_step_table.sv
// Step table: DEPTH words, synchronous write, combinational read,
// asynchronous clear to zero.
module abc_step_table
    import abc_stim_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = $bits(step_t)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    // Table storage: whole array cleared by reset, one word per write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/abc_stim_checker.sv
// Table-driven a/b/c stimulus generator with z response checking.
// Optional build macro: FIRST_FAIL_EN adds fail_valid/fail_idx.
module abc_stim_checker
    import abc_stim_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [3+HOLD_W:0]          wr_data,
    input  logic [$clog2(DEPTH)-1:0]   last_idx,
    input  logic                       start,
    output logic                       a,
    output logic                       b,
    output logic                       c,
    input  logic                       z,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [$clog2(DEPTH):0]     err_cnt
`ifdef FIRST_FAIL_EN
    ,
    output logic                       fail_valid,
    output logic [$clog2(DEPTH)-1:0]   fail_idx
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = AW + 1;
    localparam int SW = 4 + HOLD_W;

    localparam logic [AW-1:0]     IDX_ONE  = 1;
    localparam logic [HOLD_W-1:0] HOLD_ONE = 1;
    localparam logic [EW-1:0]     ERR_ONE  = 1;
    localparam logic [EW-1:0]     ERR_MAX  = '1;

    state_e            r_state;
    state_e            w_next;
    logic [AW-1:0]     r_idx;
    logic [AW-1:0]     r_last;
    logic [HOLD_W-1:0] r_cnt;
    logic [EW-1:0]     r_err;
    logic              r_pass;

    logic [SW-1:0]     w_rd;
    logic [2:0]        w_abc;
    logic              w_expz;
    logic [HOLD_W-1:0] w_hold;
    logic              w_step_last;
    logic              w_sample;
    logic              w_mis;
    logic              w_run_end;
    logic              w_accept;
    logic              w_we;
    logic [EW-1:0]     w_err_nxt;
    logic              w_busy;
    logic              w_done;
    logic              w_drive;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_we     = (r_state == S_IDLE) && wr_en;

    abc_step_table #(
        .DEPTH (DEPTH),
        .W     (SW)
    ) u_table (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_we    (w_we),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_raddr (r_idx),
        .o_rdata (w_rd)
    );

    assign w_abc  = w_rd[SW-1 -: 3];
    assign w_expz = w_rd[HOLD_W];
    assign w_hold = w_rd[HOLD_W-1:0];

    // A hold of zero is treated as a single-cycle step.
    assign w_step_last = (w_hold == '0) || (r_cnt == w_hold - HOLD_ONE);
    assign w_sample    = (r_state == S_DRIVE) && w_step_last;
    assign w_mis       = w_sample && (z != w_expz);
    assign w_run_end   = w_sample && (r_idx == r_last);
    assign w_err_nxt   = (w_mis && r_err != ERR_MAX) ? r_err + ERR_ONE
                                                      : r_err;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and state-decoded outputs.
    always_comb begin
        w_next  = r_state;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_drive = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_busy  = 1'b1;
                w_drive = 1'b1;
                if (w_run_end) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Step sequencing, mismatch counting and pass verdict.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx  <= '0;
            r_last <= '0;
            r_cnt  <= '0;
            r_err  <= '0;
            r_pass <= 1'b0;
        end else if (w_accept) begin
            r_idx  <= '0;
            r_last <= last_idx;
            r_cnt  <= '0;
            r_err  <= '0;
            r_pass <= 1'b0;
        end else if (r_state == S_DRIVE) begin
            if (w_step_last) begin
                r_cnt <= '0;
                r_err <= w_err_nxt;
                if (r_idx == r_last) begin
                    r_pass <= (w_err_nxt == '0);
                end else begin
                    r_idx <= r_idx + IDX_ONE;
                end
            end else begin
                r_cnt <= r_cnt + HOLD_ONE;
            end
        end
    end

`ifdef FIRST_FAIL_EN
    logic          r_fail_valid;
    logic [AW-1:0] r_fail_idx;

    // Remember the step index of the first mismatch in a run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
        end else if (w_accept) begin
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
        end else if (w_mis && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_idx   <= r_idx;
        end
    end

    assign fail_valid = r_fail_valid;
    assign fail_idx   = r_fail_idx;
`endif

    assign a       = w_drive & w_abc[2];
    assign b       = w_drive & w_abc[1];
    assign c       = w_drive & w_abc[0];
    assign busy    = w_busy;
    assign done    = w_done;
    assign pass    = r_pass;
    assign err_cnt = r_err;

endmodule

// File: tb/tb_abc_stim_checker.sv
// Self-checking bench for abc_stim_checker against a step-list model.
// Build with FIRST_FAIL_EN defined to also exercise fail_valid/fail_idx.
module tb_abc_stim_checker;
    import abc_stim_pkg::*;

    localparam int DEPTH = 8;
    localparam int HW    = 4;
    localparam int EMAX  = 15;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] last_idx;
    logic       start;
    logic       a, b, c;
    logic       z;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_cnt;
`ifdef FIRST_FAIL_EN
    logic       fail_valid;
    logic [2:0] fail_idx;
`endif

    abc_stim_checker #(
        .DEPTH  (DEPTH),
        .HOLD_W (HW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .last_idx (last_idx),
        .start    (start),
        .a        (a),
        .b        (b),
        .c        (c),
        .z        (z),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt)
`ifdef FIRST_FAIL_EN
        ,
        .fail_valid (fail_valid),
        .fail_idx   (fail_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference table: what the bench believes the DUT holds.
    int t_abc  [DEPTH];
    int t_expz [DEPTH];
    int t_hold [DEPTH];

    function automatic logic [7:0] pack(input int ab, input int ez,
                                        input int h);
        step_t s;
        s.abc  = ab[2:0];
        s.expz = ez[0];
        s.hold = h[3:0];
        return s;
    endfunction

    task automatic write_entry(input int idx, input int ab, input int ez,
                               input int h);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = idx[2:0];
        wr_data = pack(ab, ez, h);
        @(negedge clk);
        wr_en   = 1'b0;
        t_abc[idx]  = ab;
        t_expz[idx] = ez;
        t_hold[idx] = h;
    endtask

    // zmode: 0 = respond correctly, 1 = z tied low, 2 = random z.
    // inj: cycle at which start+write to entry 0 are pushed mid-run.
    // wr_s: write entry 0 with wd in the same cycle as start.
    task automatic run(input int last, input int zmode, input int inj,
                       input bit wr_s, input logic [7:0] wd,
                       input string nm);
        int q_abc[$];
        int q_samp[$];
        int q_z[$];
        int q_step[$];
        int n;
        int exp_err;
        int ff_v;
        int ff_i;
        int got;
        if (wr_s) begin
            t_abc[0]  = int'(wd[7:5]);
            t_expz[0] = int'(wd[4]);
            t_hold[0] = int'(wd[3:0]);
        end
        for (int i = 0; i <= last; i++) begin
            n = (t_hold[i] == 0) ? 1 : t_hold[i];
            for (int j = 0; j < n; j++) begin
                q_abc.push_back(t_abc[i]);
                q_samp.push_back(j == n - 1 ? 1 : 0);
                q_z.push_back(t_expz[i]);
                q_step.push_back(i);
            end
        end
        exp_err = 0;
        ff_v = 0;
        ff_i = 0;
        @(negedge clk);
        start    = 1'b1;
        last_idx = last[2:0];
        if (wr_s) begin
            wr_en   = 1'b1;
            wr_addr = 3'd0;
            wr_data = wd;
        end
        @(posedge clk);
        for (int k = 0; k < q_abc.size(); k++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            got = int'({a, b, c});
            n_tests++;
            if (got !== q_abc[k] || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s drive cyc%0d: abc=%0d busy=%0b done=%0b, want abc=%0d busy=1 done=0",
                         nm, k + 1, got, busy, done, q_abc[k]);
            end
            if (zmode == 0) z = q_z[k][0];
            else if (zmode == 1) z = 1'b0;
            else z = 1'($urandom);
            if (q_samp[k] == 1 && int'(z) != q_z[k]) begin
                if (exp_err < EMAX) exp_err++;
                if (ff_v == 0) begin
                    ff_v = 1;
                    ff_i = q_step[k];
                end
            end
            if (k == inj) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = 3'd0;
                wr_data = pack(7, 1, 5);
            end
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        got = int'({a, b, c});
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || got !== 0) begin
            n_fail++;
            $display("FAIL %s done-cycle: done=%0b busy=%0b abc=%0d, want 1 0 0",
                     nm, done, busy, got);
        end
        n_tests++;
        if (int'(err_cnt) !== exp_err || pass !== (exp_err == 0)) begin
            n_fail++;
            $display("FAIL %s verdict: err_cnt=%0d pass=%0b, want err_cnt=%0d pass=%0b",
                     nm, err_cnt, pass, exp_err, exp_err == 0);
        end
`ifdef FIRST_FAIL_EN
        n_tests++;
        if (int'(fail_valid) !== ff_v || (ff_v == 1 && int'(fail_idx) !== ff_i)) begin
            n_fail++;
            $display("FAIL %s first-fail: valid=%0b idx=%0d, want valid=%0d idx=%0d",
                     nm, fail_valid, fail_idx, ff_v, ff_i);
        end
`endif
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || int'(err_cnt) !== exp_err ||
            pass !== (exp_err == 0)) begin
            n_fail++;
            $display("FAIL %s hold-after: done=%0b busy=%0b err=%0d pass=%0b, want 0 0 %0d %0b",
                     nm, done, busy, err_cnt, pass, exp_err, exp_err == 0);
        end
    endtask

    task automatic test_reset;
        #1;
        n_tests++;
        if ({a, b, c, busy, done, pass} !== 6'b0 || err_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset: abc=%b busy=%b done=%b pass=%b err=%0d, want all 0",
                     {a, b, c}, busy, done, pass, err_cnt);
        end
`ifdef FIRST_FAIL_EN
        n_tests++;
        if (fail_valid !== 1'b0 || fail_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_ff: valid=%b idx=%0d, want 0 0", fail_valid, fail_idx);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        write_entry(0, 3'b000, 0, 2);
        write_entry(1, 3'b100, 0, 1);
        write_entry(2, 3'b110, 1, 3);
        run(2, 0, -1, 1'b0, 8'h00, "basic");
    endtask

    task automatic test_z_low;
        run(2, 1, -1, 1'b0, 8'h00, "z_low");
    endtask

    task automatic test_hold_zero;
        write_entry(0, 3'b101, 1, 0);
        run(0, 0, -1, 1'b0, 8'h00, "hold0");
    endtask

    task automatic test_busy_ignore;
        write_entry(0, 3'b011, 0, 2);
        run(2, 0, 1, 1'b0, 8'h00, "busy_ign");
        run(0, 0, -1, 1'b0, 8'h00, "old_entry");
    endtask

    task automatic test_write_start;
        run(0, 0, -1, 1'b1, pack(3'b111, 1, 1), "wr_start");
    endtask

    task automatic test_reset_midrun;
        write_entry(0, 3'b001, 1, 2);
        write_entry(1, 3'b010, 1, 2);
        write_entry(2, 3'b100, 0, 1);
        @(negedge clk);
        start    = 1'b1;
        last_idx = 3'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        z     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({a, b, c} !== 3'b010 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_step1: abc=%b busy=%b, want 010 1", {a, b, c}, busy);
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({a, b, c, busy, done, pass} !== 6'b0 || err_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: abc=%b busy=%b done=%b pass=%b err=%0d, want all 0",
                     {a, b, c}, busy, done, pass, err_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            t_abc[i]  = 0;
            t_expz[i] = 0;
            t_hold[i] = 0;
        end
        run(2, 0, -1, 1'b0, 8'h00, "rerun_zero");
    endtask

    task automatic test_random;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                write_entry(i, int'($urandom_range(7)), int'($urandom_range(1)),
                            int'($urandom_range(4)));
            end
            run(int'($urandom_range(7)), int'($urandom_range(2)), -1,
                1'b0, 8'h00, $sformatf("rand%0d", r));
        end
    endtask

`ifdef FIRST_FAIL_EN
    task automatic test_first_fail;
        write_entry(0, 3'b001, 0, 1);
        write_entry(1, 3'b010, 1, 2);
        write_entry(2, 3'b011, 0, 1);
        write_entry(3, 3'b100, 1, 1);
        run(3, 1, -1, 1'b0, 8'h00, "first_fail");
        n_tests++;
        if (fail_valid !== 1'b1 || fail_idx !== 3'd1 || err_cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL first_fail_fixed: valid=%b idx=%0d err=%0d, want 1 1 2",
                     fail_valid, fail_idx, err_cnt);
        end
    endtask
`endif

    initial begin
        reset_n  = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        last_idx = '0;
        start    = 1'b0;
        z        = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            t_abc[i]  = 0;
            t_expz[i] = 0;
            t_hold[i] = 0;
        end
        test_reset();
        test_basic();
        test_z_low();
        test_hold_zero();
        test_busy_ignore();
        test_write_start();
        test_reset_midrun();
`ifdef FIRST_FAIL_EN
        test_first_fail();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
